// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB-first, one bit per clock.
// Optional signed overflow flag: define SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             borrow_out,
  output logic             ovf
`else
  output logic             borrow_out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             bo_q;
  logic             accept;
  logic             last;
  logic             d_bit;
  logic             bout;

  // Handshake decode and the full-subtractor cell on the operand LSBs
  always_comb begin
    accept = start & ((state_q == IDLE) | (state_q == DONE));
    last   = (state_q == SHIFT) & (cnt_q == CW'(WIDTH - 1));
    d_bit  = a_q[0] ^ b_q[0] ^ brw_q;
    bout   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bo_q   <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      diff_q <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bo_q   <= 1'b0;
    end else if (state_q == SHIFT) begin
      diff_q <= {d_bit, diff_q[WIDTH-1:1]};
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      brw_q  <= bout;
      if (last) bo_q  <= bout;
      else      cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, bm_q, ovf_q;

  // Operand sign bits kept aside; overflow judged against the final MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      am_q  <= a[WIDTH-1];
      bm_q  <= b[WIDTH-1];
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= (am_q ^ bm_q) & (am_q ^ d_bit);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8 and WIDTH=4).
// Honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start4;
  logic [7:0] a, b, diff;
  logic [3:0] a4, b4, diff4;
  logic       busy, done, bo;
  logic       busy4, done4, bo4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
`ifdef SERIAL_SUB_OVF_EN
    .diff(diff), .borrow_out(bo), .ovf(ovf)
`else
    .diff(diff), .borrow_out(bo)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
`ifdef SERIAL_SUB_OVF_EN
    .diff(diff4), .borrow_out(bo4), .ovf(ovf4)
`else
    .diff(diff4), .borrow_out(bo4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vt[8];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Called at the negedge just after the accepting edge.
  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (!done && cyc < 64) begin
      if (!busy) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_res(string nm, vec_t v, int cyc);
    chk({nm, " done"}, done, 1);
    chk({nm, " busy@done"}, busy, 0);
    chk({nm, " latency"}, cyc, 8);
    chk({nm, " diff"}, diff, v.d);
    chk({nm, " borrow"}, bo, v.bo);
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, " ovf"}, ovf, v.ov);
`endif
  endtask

  task automatic run_op(string nm, vec_t v);
    int cyc;
    @(negedge clk);
    a = v.a; b = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    chk({nm, " busy"}, busy, 1);
    wait_done8(cyc);
    check_res(nm, v, cyc);
    @(negedge clk);
    chk({nm, " done drop"}, done, 0);
    chk({nm, " diff held"}, diff, v.d);
  endtask

  initial begin
    int cyc;
    vt[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{8'h10, 8'h10, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hF0, 8'h0F, 8'hE1, 1'b0, 1'b0};
    vt[5] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vt[7] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};

    // Reset held with start asserted
    rst_n = 1'b0; start = 1'b1; start4 = 1'b0;
    a = 8'h5A; b = 8'h23; a4 = '0; b4 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst diff", diff, 0);
      chk("rst borrow", bo, 0);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle done", done, 0);

    // Table of single operations
    foreach (vt[i]) run_op($sformatf("vec%0d", i), vt[i]);

    // Back-to-back with ignored mid-shift starts
    @(negedge clk);
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 5;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check_res("b2b1", vt[2], cyc);
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b done fall", done, 0);
    chk("b2b busy rise", busy, 1);
    wait_done8(cyc);
    check_res("b2b2", vt[3], cyc);

    // Reset during bit 4
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort borrow", bo, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort ovf", ovf, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort no done", done, 0);
    end
    run_op("after abort", vt[4]);

    // Exhaustive WIDTH=4, back-to-back
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
    for (int k = 0; k < 256; k++) begin
      int ea, eb, c4;
      ea = k >> 4;
      eb = k & 15;
      @(negedge clk);
      if (k < 255) begin
        a4 = 4'((k + 1) >> 4);
        b4 = 4'((k + 1) & 15);
      end else begin
        start4 = 1'b0;
      end
      c4 = 0;
      while (!done4 && c4 < 20) begin
        @(negedge clk);
        c4++;
      end
      chk($sformatf("w4 lat %0d-%0d", ea, eb), c4, 4);
      chk($sformatf("w4 diff %0d-%0d", ea, eb), diff4, (ea - eb) & 15);
      chk($sformatf("w4 bo %0d-%0d", ea, eb), bo4, (ea < eb) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor: diff = a - b, computed LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart to the team's combinational full-adder cell. It trades WIDTH cycles of latency for one-bit datapath area, with a start/busy/done handshake toward the requesting controller.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend (unsigned), captured when start is accepted
b  input  WIDTH  subtrahend (unsigned), captured when start is accepted
busy  output  1  high while in SHIFT state
done  output  1  single-cycle pulse; result valid
diff  output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
borrow_out  output  1  1 iff a < b (unsigned); held with diff

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, borrow FF=0, bit counter=0, operand shift registers=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE --start--> SHIFT
  - SHIFT --counter==WIDTH-1--> DONE
  - DONE --start--> SHIFT
  - DONE --!start--> IDLE
- Accept, at edge T, with start=1 in IDLE or DONE:
  - Latch a and b into shift registers; clear the borrow FF and the counter.
  - Clear diff and borrow_out.
  - busy=1 after T.
- Bit cell, combinational on the current LSBs ai, bi and borrow bin:
  - d = ai ^ bi ^ bin
  - bout = (~ai & bi) | (~(ai ^ bi) & bin)
- Each SHIFT edge:
  - d shifts into diff at the MSB end (diff shifts right).
  - Operand registers shift right; borrow FF <= bout; counter++.
- Timing:
  - Bit i is processed at edge T+1+i.
  - At edge T+WIDTH: state=DONE, busy=0, done=1, diff holds the full result, borrow_out=final bout.
  - done drops at edge T+WIDTH+1.
  - Total latency from accept to done is WIDTH cycles.
- start while busy=1 is ignored; operands are not resampled. a and b may change freely after accept.
- Back-to-back: start=1 during DONE is accepted at that same edge. done falls and busy rises together; no IDLE cycle.
- diff and borrow_out are valid only from done onward. During SHIFT, diff is a partial value and must not be consumed.
- a==b gives diff=0, borrow_out=0. a=0, b=2^WIDTH-1 gives diff=1, borrow_out=1.
- Reset asserted mid-SHIFT aborts immediately to the reset values; no done pulse is produced for the aborted operation.
- The counter is $clog2(WIDTH) bits wide and never wraps within an operation.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow flag.
  - ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), registered at edge T+WIDTH together with diff.
  - ovf resets to 0, is cleared on accept, and is held with diff.
  - The operand MSBs are captured into dedicated flops at accept.
- Undefined: no ovf port and no extra flops; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with start=1 and random a/b. Required: busy=0, done=0, diff=0, borrow_out=0 throughout. After release, no operation starts until start is seen.
- WIDTH=8, a=0x5A, b=0x23, start pulse at edge T. Required: busy high for cycles T..T+7, done=1 only in cycle T+8, diff=0x37, borrow_out=0.
- WIDTH=8, a=0x00, b=0xFF. Required: diff=0x01, borrow_out=1. With SERIAL_SUB_OVF_EN: ovf=0.
- Back-to-back: a=0x80, b=0x01 (expect diff=0x7F, borrow_out=0, ovf=1), then start held during DONE with a=0x10, b=0x10. Required: second done exactly 8 cycles later, diff=0x00, borrow_out=0. Start pulses asserted mid-SHIFT are ignored.
- Reset mid-operation: assert rst_n=0 at bit 4 of a=0xF0, b=0x0F. Required: all outputs return to 0 asynchronously and no done pulse. A new start afterwards gives diff=0xE1, borrow_out=0.
- Exhaustive: WIDTH=4, all 256 (a,b) pairs run back-to-back. Required: diff==(a-b)&0xF and borrow_out==(a<b) at every done.
